gcd_engine: RTL
===============

// Module: gcd_engine
// PURPOSE
//  Parametrised subtractive GCD engine: controller FSM plus A/B datapath in one block.
//  Accepts an operand pair on a start strobe, iterates A-B / B-A until equal or zero,
//  then presents the result with a one-cycle done pulse.
//  Handles zero operands, has a busy flag, and holds the result between jobs.
//  Successor to the fixed-width GCD datapath/controller pair; drop-in compute unit
//  for the DataPath-and-Controllers designs.
// PARAMETERS
//  WIDTH    16   operand/result width in bits (>=2)
// PORTS
//  clk       in   1      single clock, rising edge
//  rst_n     in   1      asynchronous, active-low reset
//  start     in   1      request; sampled only in IDLE
//  a_in      in   WIDTH  operand A, captured on the accepting edge
//  b_in      in   WIDTH  operand B, captured on the accepting edge
//  busy      out  1      high in CALC and DONE
//  done      out  1      one-cycle pulse, high while in DONE
//  gcd_out   out  WIDTH  result; stable from done until next result
//  iter_cnt  out  WIDTH  subtraction count (only with GCD_ITER_CNT_EN)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; A, B, gcd_out, iter_cnt = 0; busy=0; done=0.
//  FSM states: IDLE, CALC, DONE. All outputs are registered or decoded from state only.
//   IDLE: start=1 at edge -> A<=a_in, B<=b_in, iter_cnt<=0, go to CALC; start=0 -> stay.
//   CALC (per edge, priority order):
//    1) A==0 -> gcd_out<=B, go to DONE.
//    2) B==0 -> gcd_out<=A, go to DONE.
//    3) A==B -> gcd_out<=A, go to DONE.
//    4) A>B  -> A<=A-B.
//    5) A<B  -> B<=B-A.
//    Cases 4 and 5 also do iter_cnt++ and stay in CALC.
//   DONE: done=1 for exactly one cycle, then IDLE unconditionally.
//  start while busy: ignored, no queueing.
//   start held high: a new job is accepted on the first IDLE edge after DONE.
//  Latency: with k subtractions, done is high in the cycle after the edge at
//   start-accept + k+1. Back-to-back throughput is k+3 cycles per job.
//  Worst case is k = 2^WIDTH-2, e.g. gcd(1, 2^WIDTH-1).
//  Arithmetic: unsigned, WIDTH bits. The compare guarantees subtractions never underflow.
//   gcd(0,0)=0 with k=0. gcd(0,x)=x. gcd(x,0)=x.
//  gcd_out updates only on the CALC->DONE edge; it holds its value through IDLE and the next CALC.
//  Reset mid-operation: immediate abort to the reset values. No done pulse.
// CONFIGURATION
//  GCD_ITER_CNT_EN defined:
//   - iter_cnt port and WIDTH-bit counter are present.
//   - counter cleared on accept, incremented per subtraction, saturates at all-ones.
//   - value is held after DONE.
//  GCD_ITER_CNT_EN undefined:
//   - port and counter are absent. All other behaviour is identical.
// STRUCTURE
//  Package gcd_pkg: state typedef (IDLE/CALC/DONE, 2-bit encoding).
//   Also a compare-result typedef {EQ, GT, LT, ZA, ZB}.
//  Sub-module gcd_datapath:
//   - holds the A/B registers, comparator and the two subtractors.
//   - decodes the compare result.
//   - takes load/sub_a/sub_b strobes.
//  gcd_engine keeps the FSM, gcd_out, done/busy and the optional counter.
// TESTING
//  1) start, a=12 b=8 -> A=4 then B=4; done 3 cycles after accept; gcd_out=4; iter_cnt=2.
//  2) a=0 b=35 -> done 1 cycle after accept, gcd_out=35. a=0 b=0 -> gcd_out=0.
//  3) WIDTH=8, a=1 b=255 -> gcd_out=1 after 254 subtractions; busy high throughout.
//  4) Pulse start again mid-CALC with a=9 b=3 -> ignored; first job's result is unchanged.
//  5) rst_n low 2 cycles into a=48 b=18 -> outputs 0, no done.
//   Then new a=48 b=18 -> gcd_out=6.
//  6) start held high, a=21 b=14 -> back-to-back jobs.
//   done pulses exactly one cycle each, and jobs start k+3 cycles apart.

Source files
------------

// File: rtl/gcd_pkg.sv
// gcd_pkg: shared FSM state and compare-result types for the GCD engine
package gcd_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  typedef enum logic [2:0] {EQ, GT, LT, ZA, ZB} cmp_t;
endpackage

// File: rtl/gcd_datapath.sv
// gcd_datapath: A/B operand registers, comparator and the two subtractors
module gcd_datapath
  import gcd_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             sub_a,
  input  logic             sub_b,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output cmp_t             cmp
);
  // zero checks take priority so a zero operand ends the job before any subtraction
  assign cmp = a == '0 ? ZA : b == '0 ? ZB : a == b ? EQ : a > b ? GT : LT;
  // load operands on accept, otherwise subtract the smaller from the larger
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a <= '0;
      b <= '0;
    end else if (load) begin
      a <= a_in;
      b <= b_in;
    end else begin
      if (sub_a) a <= a - b;
      if (sub_b) b <= b - a;
    end
  end
endmodule

// File: rtl/gcd_engine.sv
// gcd_engine: subtractive GCD unit with one-cycle done pulse; GCD_ITER_CNT_EN adds an iteration counter
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] gcd_out
`ifdef GCD_ITER_CNT_EN
  ,
  output logic [WIDTH-1:0] iter_cnt
`endif
);
  state_t           state;
  cmp_t             cmp;
  logic [WIDTH-1:0] a, b;
  logic             load, sub_a, sub_b;
  assign load  = state == IDLE && start;
  assign sub_a = state == CALC && cmp == GT;
  assign sub_b = state == CALC && cmp == LT;
  gcd_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk(clk), .rst_n(rst_n), .load(load), .sub_a(sub_a), .sub_b(sub_b),
    .a_in(a_in), .b_in(b_in), .a(a), .b(b), .cmp(cmp)
  );
  // controller: sequences IDLE/CALC/DONE and registers busy, done and the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      gcd_out <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= CALC;
          busy  <= 1'b1;
        end
        CALC: if (cmp == ZA || cmp == ZB || cmp == EQ) begin
          state   <= DONE;
          done    <= 1'b1;
          gcd_out <= cmp == ZA ? b : a;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
`ifdef GCD_ITER_CNT_EN
  // subtraction counter: cleared on accept, saturating, held after the job
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) iter_cnt <= '0;
    else if (load) iter_cnt <= '0;
    else if ((sub_a || sub_b) && !(&iter_cnt)) iter_cnt <= iter_cnt + 1'b1;
  end
`endif
endmodule
